// File: rtl/ddr3_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ddr3_pkg
// Description : Shared definitions for the DDR3 write sequencer: command
//               encodings {cs_n,ras_n,cas_n,we_n}, sequencer state enum,
//               default DRAM timing values and common widths.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package ddr3_pkg;

  // Command encodings, bit order {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_PRE   = 4'b0010;
  localparam logic [3:0] CMD_NOP   = 4'b0111;
  // Deselect: driven while in reset so the device sees cs_n high
  localparam logic [3:0] CMD_DES   = 4'b1111;

  // Default timing values, in controller clock cycles
  localparam int DEF_T_RCD = 5;
  localparam int DEF_T_WL  = 5;
  localparam int DEF_T_WR  = 6;
  localparam int DEF_T_RP  = 5;

  // DRAM address bus width and wait-counter width
  localparam int ADDR_W = 15;
  localparam int CNT_W  = 8;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_PRE       = 4'd1,
    S_WAIT_RP   = 4'd2,
    S_ACT       = 4'd3,
    S_WAIT_RCD  = 4'd4,
    S_WRITE     = 4'd5,
    S_WAIT_WL   = 4'd6,
    S_DATA      = 4'd7,
    S_WAIT_WR   = 4'd8,
    S_WAIT_APRP = 4'd9
  } state_t;

endpackage
`default_nettype wire

// File: rtl/ddr3_write_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : ddr3_write_seq_if
// Description : Bundle of the write-request handshake, write-data stream and
//               DRAM command/data pins of the DDR3 write sequencer.
// Ports       : modport slave  - the sequencer (takes requests, drives DRAM)
//               modport master - the requester / environment
// Revision    : 1.0 - initial release
// ============================================================================
interface ddr3_write_seq_if
  import ddr3_pkg::*;
#(
  parameter int ROW_W = 15,
  parameter int COL_W = 10,
  parameter int BA_W  = 3,
  parameter int DQ_W  = 16
) ();

  // Request channel
  logic             req_valid;
  logic             req_ready;
  logic [ROW_W-1:0] req_row;
  logic [COL_W-1:0] req_col;
  logic [BA_W-1:0]  req_ba;
  logic             req_ap;
  logic             req_bl8;

  // Write data channel
  logic [DQ_W-1:0]  wdata;
  logic             wdata_valid;
  logic             wdata_ready;

  // DRAM side
  logic              cs_n;
  logic              ras_n;
  logic              cas_n;
  logic              we_n;
  logic [ADDR_W-1:0] addr;
  logic [BA_W-1:0]   ba;
  logic [DQ_W/8-1:0] dm;
  logic [DQ_W-1:0]   dq_out;
  logic              dq_oe;

  modport slave (
    input  req_valid, req_row, req_col, req_ba, req_ap, req_bl8,
    input  wdata, wdata_valid,
    output req_ready, wdata_ready,
    output cs_n, ras_n, cas_n, we_n, addr, ba, dm, dq_out, dq_oe
  );

  modport master (
    output req_valid, req_row, req_col, req_ba, req_ap, req_bl8,
    output wdata, wdata_valid,
    input  req_ready, wdata_ready,
    input  cs_n, ras_n, cas_n, we_n, addr, ba, dm, dq_out, dq_oe
  );

endinterface
`default_nettype wire

// File: rtl/ddr3_delay_cnt.sv
`default_nettype none
// ============================================================================
// Module      : ddr3_delay_cnt
// Description : Loadable down-counter shared by every wait state. Loading N
//               gives N+1 cycles of 'done' low-to-high travel: done is high in
//               the cycle where the count has reached zero.
// Ports       : clk, areset   - clock, async active-high reset
//               load          - load load_val at the next rising edge
//               load_val      - value to load
//               done          - count is zero
// Revision    : 1.0 - initial release
// ============================================================================
module ddr3_delay_cnt #(
  parameter int WIDTH = 8
) (
  input  wire logic             clk,
  input  wire logic             areset,
  input  wire logic             load,
  input  wire logic [WIDTH-1:0] load_val,
  output logic                  done
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign done = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/ddr3_write_seq.sv
`default_nettype none
// ============================================================================
// Module      : ddr3_write_seq
// Description : Single-request DDR3 write sequencer with open-row tracking.
//               Issues PRE/ACT/WRITE as needed, streams a BC4 or BL8 burst and
//               honours tRCD, tWL, tWR and tRP (including auto-precharge).
// Ports       : clk       - clock, rising edge
//               areset    - asynchronous active-high reset
//               bus       - request, write-data and DRAM pins (slave modport)
//               row_open  - a row is currently open (open_ba/open_row valid)
//               busy      - sequencer is not idle
// Revision    : 1.0 - initial release
// ============================================================================
module ddr3_write_seq
  import ddr3_pkg::*;
#(
  parameter int ROW_W = 15,
  parameter int COL_W = 10,
  parameter int BA_W  = 3,
  parameter int DQ_W  = 16,
  parameter int T_RCD = DEF_T_RCD,
  parameter int T_WL  = DEF_T_WL,
  parameter int T_WR  = DEF_T_WR,
  parameter int T_RP  = DEF_T_RP
) (
  input  wire logic         clk,
  input  wire logic         areset,
  ddr3_write_seq_if.slave   bus,
  output logic              row_open,
  output logic              busy
);

  // Cycles spent in each wait state; a zero count skips the state entirely.
  localparam int C_RP_WAIT  = T_RP - 1;
  localparam int C_RCD_WAIT = T_RCD - 1;
  localparam int C_WL_WAIT  = T_WL - 1;

  // Counter load values: the counter is loaded with (cycles - 1).
  localparam logic [CNT_W-1:0] C_LD_RP   = CNT_W'((C_RP_WAIT  > 0) ? C_RP_WAIT  - 1 : 0);
  localparam logic [CNT_W-1:0] C_LD_RCD  = CNT_W'((C_RCD_WAIT > 0) ? C_RCD_WAIT - 1 : 0);
  localparam logic [CNT_W-1:0] C_LD_WL   = CNT_W'((C_WL_WAIT  > 0) ? C_WL_WAIT  - 1 : 0);
  localparam logic [CNT_W-1:0] C_LD_WR   = CNT_W'(T_WR - 1);
  localparam logic [CNT_W-1:0] C_LD_APRP = CNT_W'(T_RP - 1);

  state_t            r_state;
  logic [ROW_W-1:0]  r_row;
  logic [COL_W-1:0]  r_col;
  logic [BA_W-1:0]   r_ba;
  logic              r_ap;
  logic              r_bl8;
  logic [ROW_W-1:0]  r_open_row;
  logic [BA_W-1:0]   r_open_ba;
  logic              r_row_open;
  logic              r_req_ready;
  logic [3:0]        r_cmd;
  logic [ADDR_W-1:0] r_addr;
  logic [BA_W-1:0]   r_ba_out;
  logic              r_dq_oe;
  logic              r_wdata_ready;
  logic [DQ_W-1:0]   r_dq_hold;
  logic [2:0]        r_beat;

  logic              w_accept;
  logic              w_hit;
  logic              w_last_beat;
  logic              w_cnt_load;
  logic [CNT_W-1:0]  w_cnt_val;
  logic              w_cnt_done;

  function automatic logic [ADDR_W-1:0] f_act_addr(input logic [ROW_W-1:0] row);
    logic [ADDR_W-1:0] a;
    a            = '0;
    a[ROW_W-1:0] = row;
    return a;
  endfunction

  // A10 carries auto-precharge, A12 selects BL8 (1) or BC4 (0).
  function automatic logic [ADDR_W-1:0] f_wr_addr(input logic [COL_W-1:0] col,
                                                  input logic ap,
                                                  input logic bl8);
    logic [ADDR_W-1:0] a;
    a            = '0;
    a[COL_W-1:0] = col;
    a[10]        = ap;
    a[12]        = bl8;
    return a;
  endfunction

  assign w_accept    = bus.req_valid && r_req_ready;
  assign w_hit       = r_row_open && (r_open_ba == bus.req_ba) && (r_open_row == bus.req_row);
  assign w_last_beat = (r_beat == (r_bl8 ? 3'd7 : 3'd3));

  // The counter is loaded on the edge that enters a wait state, so the load
  // request is raised from the state that precedes it.
  always_comb begin
    w_cnt_load = 1'b0;
    w_cnt_val  = '0;
    unique case (r_state)
      S_PRE: begin
        w_cnt_load = (C_RP_WAIT > 0);
        w_cnt_val  = C_LD_RP;
      end
      S_ACT: begin
        w_cnt_load = (C_RCD_WAIT > 0);
        w_cnt_val  = C_LD_RCD;
      end
      S_WRITE: begin
        w_cnt_load = (C_WL_WAIT > 0);
        w_cnt_val  = C_LD_WL;
      end
      S_DATA: begin
        w_cnt_load = w_last_beat;
        w_cnt_val  = C_LD_WR;
      end
      S_WAIT_WR: begin
        w_cnt_load = w_cnt_done && r_ap;
        w_cnt_val  = C_LD_APRP;
      end
      default: begin
        w_cnt_load = 1'b0;
        w_cnt_val  = '0;
      end
    endcase
  end

  ddr3_delay_cnt #(
    .WIDTH (CNT_W)
  ) u_delay_cnt (
    .clk      (clk),
    .areset   (areset),
    .load     (w_cnt_load),
    .load_val (w_cnt_val),
    .done     (w_cnt_done)
  );

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_state       <= S_IDLE;
      r_row         <= '0;
      r_col         <= '0;
      r_ba          <= '0;
      r_ap          <= 1'b0;
      r_bl8         <= 1'b0;
      r_open_row    <= '0;
      r_open_ba     <= '0;
      r_row_open    <= 1'b0;
      r_req_ready   <= 1'b0;
      r_cmd         <= CMD_DES;
      r_addr        <= '0;
      r_ba_out      <= '0;
      r_dq_oe       <= 1'b0;
      r_wdata_ready <= 1'b0;
      r_dq_hold     <= '0;
      r_beat        <= '0;
    end else begin
      // Command bus idles as NOP with a cleared address unless a command issues.
      r_cmd    <= CMD_NOP;
      r_addr   <= '0;
      r_ba_out <= '0;

      unique case (r_state)
        S_IDLE: begin
          r_req_ready <= 1'b1;
          if (w_accept) begin
            r_req_ready <= 1'b0;
            r_row       <= bus.req_row;
            r_col       <= bus.req_col;
            r_ba        <= bus.req_ba;
            r_ap        <= bus.req_ap;
            r_bl8       <= bus.req_bl8;
            if (w_hit) begin
              r_state  <= S_WRITE;
              r_cmd    <= CMD_WRITE;
              r_addr   <= f_wr_addr(bus.req_col, bus.req_ap, bus.req_bl8);
              r_ba_out <= bus.req_ba;
            end else if (r_row_open) begin
              // A10 low: precharge only the currently open bank.
              r_state    <= S_PRE;
              r_cmd      <= CMD_PRE;
              r_ba_out   <= r_open_ba;
              r_row_open <= 1'b0;
            end else begin
              r_state    <= S_ACT;
              r_cmd      <= CMD_ACT;
              r_addr     <= f_act_addr(bus.req_row);
              r_ba_out   <= bus.req_ba;
              r_open_row <= bus.req_row;
              r_open_ba  <= bus.req_ba;
              r_row_open <= 1'b1;
            end
          end
        end

        S_PRE, S_WAIT_RP: begin
          if ((r_state == S_PRE && C_RP_WAIT == 0) || (r_state == S_WAIT_RP && w_cnt_done)) begin
            r_state    <= S_ACT;
            r_cmd      <= CMD_ACT;
            r_addr     <= f_act_addr(r_row);
            r_ba_out   <= r_ba;
            r_open_row <= r_row;
            r_open_ba  <= r_ba;
            r_row_open <= 1'b1;
          end else begin
            r_state <= S_WAIT_RP;
          end
        end

        S_ACT, S_WAIT_RCD: begin
          if ((r_state == S_ACT && C_RCD_WAIT == 0) || (r_state == S_WAIT_RCD && w_cnt_done)) begin
            r_state  <= S_WRITE;
            r_cmd    <= CMD_WRITE;
            r_addr   <= f_wr_addr(r_col, r_ap, r_bl8);
            r_ba_out <= r_ba;
          end else begin
            r_state <= S_WAIT_RCD;
          end
        end

        S_WRITE, S_WAIT_WL: begin
          if ((r_state == S_WRITE && C_WL_WAIT == 0) || (r_state == S_WAIT_WL && w_cnt_done)) begin
            r_state       <= S_DATA;
            r_dq_oe       <= 1'b1;
            r_wdata_ready <= 1'b1;
            r_beat        <= '0;
          end else begin
            r_state <= S_WAIT_WL;
          end
        end

        S_DATA: begin
          // A missing beat is masked rather than stalled; the pins keep the
          // last real data so dq does not toggle needlessly.
          if (bus.wdata_valid) begin
            r_dq_hold <= bus.wdata;
          end
          if (w_last_beat) begin
            r_state       <= S_WAIT_WR;
            r_dq_oe       <= 1'b0;
            r_wdata_ready <= 1'b0;
          end else begin
            r_beat <= r_beat + 3'd1;
          end
        end

        S_WAIT_WR: begin
          if (w_cnt_done) begin
            if (r_ap) begin
              r_state <= S_WAIT_APRP;
            end else begin
              r_state     <= S_IDLE;
              r_req_ready <= 1'b1;
            end
          end
        end

        S_WAIT_APRP: begin
          if (w_cnt_done) begin
            r_state     <= S_IDLE;
            r_row_open  <= 1'b0;
            r_req_ready <= 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready   = r_req_ready;
  assign bus.wdata_ready = r_wdata_ready;
  assign bus.cs_n        = r_cmd[3];
  assign bus.ras_n       = r_cmd[2];
  assign bus.cas_n       = r_cmd[1];
  assign bus.we_n        = r_cmd[0];
  assign bus.addr        = r_addr;
  assign bus.ba          = r_ba_out;
  assign bus.dq_oe       = r_dq_oe;

  // Beat data passes straight through in the cycle it is presented so a beat
  // offered while wdata_ready is high lands on the pins in that same cycle.
  assign bus.dq_out = (r_dq_oe && bus.wdata_valid) ? bus.wdata : r_dq_hold;
  assign bus.dm     = (r_dq_oe && bus.wdata_valid) ? '0 : '1;

  assign row_open = r_row_open;
  assign busy     = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ddr3_write_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_ddr3_write_seq
// Description : Directed self-checking bench for ddr3_write_seq with
//               hand-computed command timing, address and data expectations.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr3_write_seq;

  localparam int ROW_W = 15;
  localparam int COL_W = 10;
  localparam int BA_W  = 3;
  localparam int DQ_W  = 16;
  localparam int NCAP  = 40;

  localparam logic [3:0] E_ACT   = 4'b0011;
  localparam logic [3:0] E_WRITE = 4'b0100;
  localparam logic [3:0] E_PRE   = 4'b0010;
  localparam logic [3:0] E_NOP   = 4'b0111;

  logic clk = 1'b0;
  logic areset;
  logic row_open;
  logic busy;

  always #5 clk = ~clk;

  ddr3_write_seq_if #(.ROW_W(ROW_W), .COL_W(COL_W), .BA_W(BA_W), .DQ_W(DQ_W)) bus ();

  ddr3_write_seq #(
    .ROW_W (ROW_W),
    .COL_W (COL_W),
    .BA_W  (BA_W),
    .DQ_W  (DQ_W),
    .T_RCD (5),
    .T_WL  (5),
    .T_WR  (6),
    .T_RP  (5)
  ) dut (
    .clk      (clk),
    .areset   (areset),
    .bus      (bus),
    .row_open (row_open),
    .busy     (busy)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [3:0]  cap_cmd  [NCAP];
  logic [14:0] cap_addr [NCAP];
  logic [2:0]  cap_ba   [NCAP];
  logic        cap_oe   [NCAP];
  logic [1:0]  cap_dm   [NCAP];
  logic [15:0] cap_dq   [NCAP];
  logic        cap_busy [NCAP];
  logic        cap_rdy  [NCAP];
  logic [NCAP-1:0] hole_mask;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Offers a request at a falling edge and returns just after the accepting edge.
  task automatic send_req(input logic [ROW_W-1:0] row, input logic [COL_W-1:0] col,
                          input logic [BA_W-1:0] ba, input logic ap, input logic bl8);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    bus.req_row   = row;
    bus.req_col   = col;
    bus.req_ba    = ba;
    bus.req_ap    = ap;
    bus.req_bl8   = bl8;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (bus.req_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check_val("req_accepted", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  // Cycle k = 0 is the cycle right after the accepting edge.
  task automatic capture(input int n);
    for (int k = 0; k < n; k++) begin
      bus.wdata       = 16'hD000 | 16'(k);
      bus.wdata_valid = !hole_mask[k];
      @(negedge clk);
      cap_cmd[k]  = {bus.cs_n, bus.ras_n, bus.cas_n, bus.we_n};
      cap_addr[k] = bus.addr;
      cap_ba[k]   = bus.ba;
      cap_oe[k]   = bus.dq_oe;
      cap_dm[k]   = bus.dm;
      cap_dq[k]   = bus.dq_out;
      cap_busy[k] = busy;
      cap_rdy[k]  = bus.req_ready;
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int count_cmds(input int n);
    int c;
    c = 0;
    for (int k = 0; k < n; k++) if (cap_cmd[k] != E_NOP) c++;
    return c;
  endfunction

  function automatic int count_oe(input int n);
    int c;
    c = 0;
    for (int k = 0; k < n; k++) if (cap_oe[k]) c++;
    return c;
  endfunction

  function automatic int first_oe(input int n);
    for (int k = 0; k < n; k++) if (cap_oe[k]) return k;
    return -1;
  endfunction

  task automatic check_reset_outputs(input string pfx);
    check_val({pfx, "_cs_n"},   32'(bus.cs_n),        32'd1);
    check_val({pfx, "_addr"},   32'(bus.addr),        32'd0);
    check_val({pfx, "_ba"},     32'(bus.ba),          32'd0);
    check_val({pfx, "_dm"},     32'(bus.dm),          32'h3);
    check_val({pfx, "_dq_out"}, 32'(bus.dq_out),      32'd0);
    check_val({pfx, "_dq_oe"},  32'(bus.dq_oe),       32'd0);
    check_val({pfx, "_wrdy"},   32'(bus.wdata_ready), 32'd0);
    check_val({pfx, "_busy"},   32'(busy),            32'd0);
    check_val({pfx, "_rowopen"},32'(row_open),        32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    areset          = 1'b1;
    hole_mask       = '0;
    bus.req_valid   = 1'b0;
    bus.req_row     = '0;
    bus.req_col     = '0;
    bus.req_ba      = '0;
    bus.req_ap      = 1'b0;
    bus.req_bl8     = 1'b0;
    bus.wdata       = '0;
    bus.wdata_valid = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    check_val("rst_req_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    areset = 1'b0;
    @(negedge clk);
    check_val("ready_after_rst", 32'(bus.req_ready), 32'd1);

    // Closed row, BL8, no auto-precharge
    send_req(15'h0001, 10'h010, 3'd0, 1'b0, 1'b1);
    capture(30);
    check_val("t1_act_cmd",   32'(cap_cmd[0]),  32'(E_ACT));
    check_val("t1_act_addr",  32'(cap_addr[0]), 32'h0001);
    check_val("t1_wr_cmd",    32'(cap_cmd[5]),  32'(E_WRITE));
    check_val("t1_wr_addr",   32'(cap_addr[5]), 32'h1010);
    check_val("t1_ncmds",     32'(count_cmds(30)), 32'd2);
    check_val("t1_first_oe",  32'(first_oe(30)),   32'd10);
    check_val("t1_n_oe",      32'(count_oe(30)),   32'd8);
    check_val("t1_dq_beat0",  32'(cap_dq[10]), 32'hD00A);
    check_val("t1_dm_beat0",  32'(cap_dm[10]), 32'h0);
    check_val("t1_dq_beat7",  32'(cap_dq[17]), 32'hD011);
    check_val("t1_busy_23",   32'(cap_busy[23]), 32'd1);
    check_val("t1_busy_24",   32'(cap_busy[24]), 32'd0);
    check_val("t1_rdy_24",    32'(cap_rdy[24]),  32'd1);
    check_val("t1_dm_idle",   32'(cap_dm[20]),   32'h3);
    check_val("t1_row_open",  32'(row_open),     32'd1);

    // Row hit: WRITE straight away
    send_req(15'h0001, 10'h020, 3'd0, 1'b0, 1'b1);
    capture(24);
    check_val("t2_wr_cmd",    32'(cap_cmd[0]),  32'(E_WRITE));
    check_val("t2_wr_addr",   32'(cap_addr[0]), 32'h1020);
    check_val("t2_ncmds",     32'(count_cmds(24)), 32'd1);
    check_val("t2_first_oe",  32'(first_oe(24)),   32'd5);
    check_val("t2_busy_18",   32'(cap_busy[18]), 32'd1);
    check_val("t2_busy_19",   32'(cap_busy[19]), 32'd0);

    // Row miss in the open bank: PRE, ACT, WRITE
    send_req(15'h0002, 10'h030, 3'd0, 1'b0, 1'b1);
    capture(30);
    check_val("t3_pre_cmd",   32'(cap_cmd[0]),  32'(E_PRE));
    check_val("t3_pre_addr",  32'(cap_addr[0]), 32'h0000);
    check_val("t3_pre_ba",    32'(cap_ba[0]),   32'd0);
    check_val("t3_act_cmd",   32'(cap_cmd[5]),  32'(E_ACT));
    check_val("t3_act_addr",  32'(cap_addr[5]), 32'h0002);
    check_val("t3_wr_cmd",    32'(cap_cmd[10]), 32'(E_WRITE));
    check_val("t3_wr_addr",   32'(cap_addr[10]), 32'h1030);
    check_val("t3_ncmds",     32'(count_cmds(30)), 32'd3);
    check_val("t3_busy_29",   32'(cap_busy[29]), 32'd0);

    // BC4 with auto-precharge on the open row
    send_req(15'h0002, 10'h040, 3'd0, 1'b1, 1'b0);
    capture(24);
    check_val("t4_wr_cmd",    32'(cap_cmd[0]),  32'(E_WRITE));
    check_val("t4_wr_addr",   32'(cap_addr[0]), 32'h0440);
    check_val("t4_n_oe",      32'(count_oe(24)),   32'd4);
    check_val("t4_first_oe",  32'(first_oe(24)),   32'd5);
    check_val("t4_busy_19",   32'(cap_busy[19]), 32'd1);
    check_val("t4_busy_20",   32'(cap_busy[20]), 32'd0);
    check_val("t4_rdy_20",    32'(cap_rdy[20]),  32'd1);
    check_val("t4_row_open",  32'(row_open),     32'd0);

    // BL8 with beats 3 and 5 (counting from 1) not supplied
    hole_mask[12] = 1'b1;
    hole_mask[14] = 1'b1;
    send_req(15'h0003, 10'h050, 3'd1, 1'b0, 1'b1);
    capture(24);
    hole_mask = '0;
    check_val("t5_act_cmd",   32'(cap_cmd[0]),  32'(E_ACT));
    check_val("t5_act_ba",    32'(cap_ba[0]),   32'd1);
    check_val("t5_wr_addr",   32'(cap_addr[5]), 32'h1050);
    check_val("t5_n_oe",      32'(count_oe(24)), 32'd8);
    for (int k = 10; k < 18; k++) begin
      check_val($sformatf("t5_dm_k%0d", k), 32'(cap_dm[k]),
                (k == 12 || k == 14) ? 32'h3 : 32'h0);
    end
    check_val("t5_dq_hold3",  32'(cap_dq[12]), 32'hD00B);
    check_val("t5_dq_beat4",  32'(cap_dq[13]), 32'hD00D);
    check_val("t5_dq_hold5",  32'(cap_dq[14]), 32'hD00D);

    // Reset pulse in beat 2 of a burst
    send_req(15'h0004, 10'h060, 3'd2, 1'b0, 1'b1);
    seen = 1'b0;
    bus.wdata       = 16'hBEEF;
    bus.wdata_valid = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.dq_oe) begin
        seen = 1'b1;
        break;
      end
    end
    check_val("t6_burst_seen", 32'(seen), 32'd1);
    @(posedge clk);
    #2;
    areset = 1'b1;
    #1;
    check_reset_outputs("t6");
    @(negedge clk);
    areset = 1'b0;
    repeat (2) @(negedge clk);
    send_req(15'h0004, 10'h060, 3'd2, 1'b0, 1'b1);
    capture(12);
    check_val("t6_act_cmd",   32'(cap_cmd[0]),  32'(E_ACT));
    check_val("t6_act_addr",  32'(cap_addr[0]), 32'h0004);
    check_val("t6_act_ba",    32'(cap_ba[0]),   32'd2);
    check_val("t6_wr_cmd",    32'(cap_cmd[5]),  32'(E_WRITE));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
